// File: rtl/output_drain_sequencer.sv
// Captures a finished block and drains its PE results as LANES-wide tagged beats; first beat the cycle after trigger, <=1 beat/cycle.
// Beats hold stable until out_ready && !stall; stall freezes everything, and empty beats are skipped at no cost.
module output_drain_sequencer #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int LANES  = 4,
  parameter int MAX_N  = 64,
  parameter int N_BITS = $clog2(MAX_N),
  parameter int MAX_CH = 64,
  parameter int C_BITS = $clog2(MAX_CH),
  localparam int PES     = ROWS * COLS,
  localparam int BEATS   = PES / LANES,
  localparam int P_BITS  = $clog2(PES),
  localparam int BI_BITS = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      done,
  input  logic                      sta_idle,
  input  logic [N_BITS-1:0]         pos_row,
  input  logic [N_BITS-1:0]         pos_col,
  input  logic [C_BITS-1:0]         pos_chan,
  input  logic [N_BITS:0]           mat_rows,
  input  logic [N_BITS:0]           mat_cols,
  input  logic [PES-1:0]            pe_mask,
  input  logic                      out_ready,
  output logic                      idle,
  output logic                      beat_valid,
  output logic                      beat_last,
  output logic [BI_BITS-1:0]        beat_idx,
  output logic [LANES-1:0]          lane_valid,
  output logic [P_BITS*LANES-1:0]   lane_pe,
  output logic [N_BITS*LANES-1:0]   lane_row,
  output logic [N_BITS*LANES-1:0]   lane_col,
  output logic [C_BITS-1:0]         out_chan,
  output logic                      drain_done
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FINISH} state_t;

  state_t              state;
  logic                armed;
  logic [N_BITS-1:0]   cap_row, cap_col;
  logic [N_BITS:0]     cap_mrows, cap_mcols;
  logic [PES-1:0]      cap_mask;

  // Bounds are compared one bit wider than coordinates so base+offset cannot wrap.
  function automatic logic [PES-1:0] eligible(input logic [N_BITS-1:0] r0, input logic [N_BITS-1:0] c0,
                                              input logic [N_BITS:0] mr, input logic [N_BITS:0] mc,
                                              input logic [PES-1:0] m);
    logic [N_BITS:0] r, c;
    eligible = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        r = {1'b0, r0} + (N_BITS+1)'(i);
        c = {1'b0, c0} + (N_BITS+1)'(j);
        eligible[i*COLS+j] = m[i*COLS+j] && (r < mr) && (c < mc);
      end
    end
  endfunction

  function automatic logic [BEATS-1:0] nonempty(input logic [PES-1:0] e);
    nonempty = '0;
    for (int b = 0; b < BEATS; b++) nonempty[b] = |e[b*LANES +: LANES];
  endfunction

  // Returns {found, index} of the lowest non-empty beat at or above start.
  function automatic logic [BI_BITS:0] find_from(input logic [BEATS-1:0] ne, input int start);
    find_from = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (b >= start && ne[b]) find_from = {1'b1, BI_BITS'(b)};
    end
  endfunction

  logic [PES-1:0]   cap_elig;
  logic [BI_BITS:0] first_in, next_cap;

  assign cap_elig = eligible(cap_row, cap_col, cap_mrows, cap_mcols, cap_mask);
  assign first_in = find_from(nonempty(eligible(pos_row, pos_col, mat_rows, mat_cols, pe_mask)), 0);
  assign next_cap = find_from(nonempty(cap_elig), int'(beat_idx) + 1);

  assign idle       = (state == S_IDLE);
  assign beat_valid = (state == S_DRAIN);
  assign beat_last  = (state == S_DRAIN) && !next_cap[BI_BITS];
  assign drain_done = (state == S_FINISH);

  always_comb begin
    int f;
    f          = 0;
    lane_valid = '0;
    lane_pe    = '0;
    lane_row   = '0;
    lane_col   = '0;
    for (int l = 0; l < LANES; l++) begin
      f = int'(beat_idx) * LANES + l;
      if (f < PES) begin
        lane_pe[l*P_BITS +: P_BITS]  = P_BITS'(f);
        lane_row[l*N_BITS +: N_BITS] = cap_row + N_BITS'(f / COLS);
        lane_col[l*N_BITS +: N_BITS] = cap_col + N_BITS'(f % COLS);
        lane_valid[l]                = (state == S_DRAIN) && cap_elig[f];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      armed     <= 1'b1;
      cap_row   <= '0;
      cap_col   <= '0;
      cap_mrows <= '0;
      cap_mcols <= '0;
      cap_mask  <= '0;
      out_chan  <= '0;
      beat_idx  <= '0;
    end else if (!stall) begin
      // A held done only triggers once; it must drop before the next drain.
      if (!done) armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (done && sta_idle && armed) begin
            armed     <= 1'b0;
            cap_row   <= pos_row;
            cap_col   <= pos_col;
            cap_mrows <= mat_rows;
            cap_mcols <= mat_cols;
            cap_mask  <= pe_mask;
            out_chan  <= pos_chan;
            if (first_in[BI_BITS]) begin
              state    <= S_DRAIN;
              beat_idx <= first_in[BI_BITS-1:0];
            end else begin
              state    <= S_FINISH;
              beat_idx <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (!next_cap[BI_BITS]) state <= S_FINISH;
            else beat_idx <= next_cap[BI_BITS-1:0];
          end
        end
        S_FINISH: begin
          state    <= S_IDLE;
          beat_idx <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_drain_sequencer.sv
// Directed cycle tables plus hand sequences for output_drain_sequencer (default 4x4, 4 lanes).
module tb_output_drain_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, done, sta_idle, out_ready;
  logic [5:0]  pos_row, pos_col, pos_chan;
  logic [6:0]  mat_rows, mat_cols;
  logic [15:0] pe_mask;
  logic        idle, beat_valid, beat_last, drain_done;
  logic [1:0]  beat_idx;
  logic [3:0]  lane_valid;
  logic [15:0] lane_pe;
  logic [23:0] lane_row, lane_col;
  logic [5:0]  out_chan;

  int checks = 0;
  int failures = 0;
  int exp_chan = 0;

  output_drain_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .done(done), .sta_idle(sta_idle),
    .pos_row(pos_row), .pos_col(pos_col), .pos_chan(pos_chan),
    .mat_rows(mat_rows), .mat_cols(mat_cols), .pe_mask(pe_mask), .out_ready(out_ready),
    .idle(idle), .beat_valid(beat_valid), .beat_last(beat_last), .beat_idx(beat_idx),
    .lane_valid(lane_valid), .lane_pe(lane_pe), .lane_row(lane_row), .lane_col(lane_col),
    .out_chan(out_chan), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, dn, sta, rdy;
    logic        e_idle, e_bv, e_bl;
    logic [1:0]  e_idx;
    logic [3:0]  e_lv;
    logic        e_dd;
    logic        lchk;
    logic [23:0] e_lr, e_lc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic stl, input logic dn, input logic sta, input logic rdy,
                              input logic e_idle, input logic e_bv, input logic e_bl, input logic [1:0] e_idx,
                              input logic [3:0] e_lv, input logic e_dd, input logic lchk,
                              input logic [23:0] e_lr, input logic [23:0] e_lc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.dn = dn; v.sta = sta; v.rdy = rdy;
    v.e_idle = e_idle; v.e_bv = e_bv; v.e_bl = e_bl; v.e_idx = e_idx;
    v.e_lv = e_lv; v.e_dd = e_dd; v.lchk = lchk; v.e_lr = e_lr; v.e_lc = e_lc;
    tbl.push_back(v);
  endfunction

  function automatic logic [23:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {6'(l3), 6'(l2), 6'(l1), 6'(l0)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int r, input int c, input int ch, input int mr, input int mc, input logic [15:0] m);
    pos_row = 6'(r); pos_col = 6'(c); pos_chan = 6'(ch);
    mat_rows = 7'(mr); mat_cols = 7'(mc); pe_mask = m;
  endtask

  task automatic run_table(input string name);
    logic [15:0] exp_pe;
    foreach (tbl[k]) begin
      reset = tbl[k].rst; stall = tbl[k].stl; done = tbl[k].dn;
      sta_idle = tbl[k].sta; out_ready = tbl[k].rdy;
      step();
      chk($sformatf("%s[%0d].idle", name, k), idle, tbl[k].e_idle);
      chk($sformatf("%s[%0d].beat_valid", name, k), beat_valid, tbl[k].e_bv);
      chk($sformatf("%s[%0d].drain_done", name, k), drain_done, tbl[k].e_dd);
      if (tbl[k].e_bv) begin
        chk($sformatf("%s[%0d].beat_idx", name, k), beat_idx, tbl[k].e_idx);
        chk($sformatf("%s[%0d].beat_last", name, k), beat_last, tbl[k].e_bl);
        chk($sformatf("%s[%0d].lane_valid", name, k), lane_valid, tbl[k].e_lv);
      end
      if (tbl[k].lchk) begin
        for (int l = 0; l < 4; l++) exp_pe[l*4 +: 4] = 4'(int'(tbl[k].e_idx) * 4 + l);
        chk($sformatf("%s[%0d].lane_row", name, k), lane_row, tbl[k].e_lr);
        chk($sformatf("%s[%0d].lane_col", name, k), lane_col, tbl[k].e_lc);
        chk($sformatf("%s[%0d].lane_pe", name, k), lane_pe, exp_pe);
        chk($sformatf("%s[%0d].out_chan", name, k), out_chan, 6'(exp_chan));
      end
    end
    tbl.delete();
  endtask

  initial begin
    int n;
    reset = 1'b1; stall = 1'b0; done = 1'b0; sta_idle = 1'b1; out_ready = 1'b0;
    cfg(8, 4, 3, 64, 64, 16'hFFFF);
    step(); step();
    chk("rst.idle", idle, 1'b1);
    chk("rst.beat_valid", beat_valid, 1'b0);
    chk("rst.beat_last", beat_last, 1'b0);
    chk("rst.drain_done", drain_done, 1'b0);
    chk("rst.lane_valid", lane_valid, 4'h0);
    chk("rst.beat_idx", beat_idx, 2'd0);
    chk("rst.out_chan", out_chan, 6'd0);
    reset = 1'b0;

    // Full drain: rows 8..11, cols 4..7, one beat per row.
    exp_chan = 3;
    add(0,0,1,1,1, 0,1,0,2'd0,4'hF,0, 1,pk(8,8,8,8),pk(4,5,6,7));
    add(0,0,0,1,1, 0,1,0,2'd1,4'hF,0, 1,pk(9,9,9,9),pk(4,5,6,7));
    add(0,0,0,1,1, 0,1,0,2'd2,4'hF,0, 1,pk(10,10,10,10),pk(4,5,6,7));
    add(0,0,0,1,1, 0,1,1,2'd3,4'hF,0, 1,pk(11,11,11,11),pk(4,5,6,7));
    add(0,0,0,1,1, 0,0,0,2'd0,4'h0,1, 0,24'd0,24'd0);
    add(0,0,0,1,1, 1,0,0,2'd0,4'h0,0, 0,24'd0,24'd0);
    run_table("full");

    // Clip + skip, then done held (no retrigger), dropped, and re-armed.
    cfg(60, 62, 5, 62, 64, 16'hFFFF);
    exp_chan = 5;
    add(0,0,1,1,1, 0,1,0,2'd0,4'h3,0, 1,pk(60,60,60,60),pk(62,63,0,1));
    add(0,0,1,1,1, 0,1,1,2'd1,4'h3,0, 1,pk(61,61,61,61),pk(62,63,0,1));
    add(0,0,1,1,1, 0,0,0,2'd0,4'h0,1, 0,24'd0,24'd0);
    add(0,0,1,1,1, 1,0,0,2'd0,4'h0,0, 0,24'd0,24'd0);
    add(0,0,1,1,1, 1,0,0,2'd0,4'h0,0, 0,24'd0,24'd0);
    add(0,0,0,1,1, 1,0,0,2'd0,4'h0,0, 0,24'd0,24'd0);
    add(0,0,1,1,1, 0,1,0,2'd0,4'h3,0, 1,pk(60,60,60,60),pk(62,63,0,1));
    add(0,0,1,1,1, 0,1,1,2'd1,4'h3,0, 1,pk(61,61,61,61),pk(62,63,0,1));
    add(0,0,1,1,1, 0,0,0,2'd0,4'h0,1, 0,24'd0,24'd0);
    add(0,0,0,1,1, 1,0,0,2'd0,4'h0,0, 0,24'd0,24'd0);
    run_table("clip");

    // Backpressure and stall; inputs scrambled after the trigger must not matter.
    cfg(8, 4, 3, 64, 64, 16'hFFFF);
    exp_chan = 3;
    add(0,0,1,1,0, 0,1,0,2'd0,4'hF,0, 1,pk(8,8,8,8),pk(4,5,6,7));
    run_table("bp_trig");
    cfg(0, 0, 9, 1, 1, 16'h0000);
    add(0,0,0,1,1, 0,1,0,2'd1,4'hF,0, 1,pk(9,9,9,9),pk(4,5,6,7));
    add(0,0,0,1,0, 0,1,0,2'd1,4'hF,0, 1,pk(9,9,9,9),pk(4,5,6,7));
    add(0,0,0,1,0, 0,1,0,2'd1,4'hF,0, 1,pk(9,9,9,9),pk(4,5,6,7));
    add(0,1,0,1,1, 0,1,0,2'd1,4'hF,0, 1,pk(9,9,9,9),pk(4,5,6,7));
    add(0,0,0,1,1, 0,1,0,2'd2,4'hF,0, 1,pk(10,10,10,10),pk(4,5,6,7));
    add(0,0,0,1,1, 0,1,1,2'd3,4'hF,0, 1,pk(11,11,11,11),pk(4,5,6,7));
    add(0,0,0,1,0, 0,1,1,2'd3,4'hF,0, 1,pk(11,11,11,11),pk(4,5,6,7));
    add(0,1,0,1,1, 0,1,1,2'd3,4'hF,0, 1,pk(11,11,11,11),pk(4,5,6,7));
    add(0,0,0,1,1, 0,0,0,2'd0,4'h0,1, 0,24'd0,24'd0);
    add(0,1,0,1,0, 0,0,0,2'd0,4'h0,1, 0,24'd0,24'd0);
    add(0,0,0,1,0, 1,0,0,2'd0,4'h0,0, 0,24'd0,24'd0);
    run_table("bp");

    // All masked: straight to FINISH; also sta_idle=0 and stall block the trigger.
    cfg(8, 4, 7, 64, 64, 16'h0000);
    add(0,0,1,0,0, 1,0,0,2'd0,4'h0,0, 0,24'd0,24'd0);
    add(0,0,1,1,0, 0,0,0,2'd0,4'h0,1, 0,24'd0,24'd0);
    add(0,0,0,1,0, 1,0,0,2'd0,4'h0,0, 0,24'd0,24'd0);
    add(0,1,1,1,0, 1,0,0,2'd0,4'h0,0, 0,24'd0,24'd0);
    add(0,0,1,1,0, 0,0,0,2'd0,4'h0,1, 0,24'd0,24'd0);
    add(0,1,0,1,0, 0,0,0,2'd0,4'h0,1, 0,24'd0,24'd0);
    add(0,0,0,1,0, 1,0,0,2'd0,4'h0,0, 0,24'd0,24'd0);
    run_table("masked");

    // Reset at beat 1, then a fresh drain from beat 0.
    cfg(8, 4, 3, 64, 64, 16'hFFFF);
    done = 1'b1; out_ready = 1'b1;
    step();
    done = 1'b0;
    step();
    chk("rmid.beat_idx", beat_idx, 2'd1);
    chk("rmid.beat_valid", beat_valid, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmid.idle", idle, 1'b1);
    chk("rmid.beat_valid_after", beat_valid, 1'b0);
    chk("rmid.no_done", drain_done, 1'b0);
    step();
    chk("rmid.no_done2", drain_done, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("rmid.restart_valid", beat_valid, 1'b1);
    chk("rmid.restart_idx", beat_idx, 2'd0);
    n = 0;
    while (!drain_done && n < 20) begin
      step();
      n++;
    end
    chk("rmid.done_latency", 64'(n), 64'd4);
    step();
    chk("rmid.idle_end", idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
